// File: rtl/apb_rr_master_if.sv
// Bundle for apb_rr_master: the local requester side and the APB3 slave port.
// The master modport is the sequencer's view; the slave modport is the clients plus the APB slave.
interface apb_rr_master_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 12,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;

  logic                PSEL;
  logic                PENABLE;
  logic [AW-1:0]       PADDR;
  logic                PWRITE;
  logic [DW-1:0]       PWDATA;
  logic                PREADY;
  logic [DW-1:0]       PRDATA;
  logic                PSLVERR;

  modport master (
    input  req, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    output gnt, done, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    input  gnt, done, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin arbiter plus APB3 master sequencer: N local requesters share one APB slave.
// Handshake: a requester holds req[i] high until it sees the one-cycle gnt[i] pulse, drops it the
// next cycle and keeps it low until done[i]; rsp_rdata/rsp_err are valid only alongside done[i].
module apb_rr_master #(
  parameter int N_REQ = 4,
  parameter int AW    = 12,
  parameter int DW    = 32,
  localparam int PW   = $clog2(N_REQ)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_rr_master_if.master bus,
  output logic [1:0]    dbg_state,
  output logic [PW-1:0] dbg_ptr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam int         SW        = PW + 1;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    cur;
  logic [PW-1:0]    cur_next;
  logic [N_REQ-1:0] cur_oh;
  logic [N_REQ-1:0] pend;
  logic [PW-1:0]    base;
  logic [SW-1:0]    scan;
  logic             win_found;
  logic [PW-1:0]    win_idx;

  assign cur_next  = (int'(cur) == N_REQ - 1) ? '0 : cur + PW'(1);
  assign cur_oh    = N_REQ'(1) << cur;
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

  // In ACCESS the arbitration for a back-to-back launch already uses the pointer
  // value that the completing transfer is about to write, so scan from cur+1.
  always_comb begin
    pend = bus.req;
    base = ptr;
    if (state == ST_ACCESS) begin
      pend = bus.req & ~cur_oh;
      base = cur_next;
    end
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, base} + SW'(i);
      if (scan >= SW'(N_REQ)) scan = scan - SW'(N_REQ);
      if (!win_found && pend[scan[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      cur           <= '0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            bus.PADDR   <= bus.req_addr[int'(win_idx)*AW +: AW];
            bus.PWDATA  <= bus.req_wdata[int'(win_idx)*DW +: DW];
            bus.PWRITE  <= bus.req_write[win_idx];
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            bus.gnt     <= N_REQ'(1) << win_idx;
            cur         <= win_idx;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.PREADY) begin
            bus.done      <= cur_oh;
            bus.rsp_rdata <= bus.PRDATA;
            bus.rsp_err   <= bus.PSLVERR;
            ptr           <= cur_next;
            if (win_found) begin
              bus.PADDR   <= bus.req_addr[int'(win_idx)*AW +: AW];
              bus.PWDATA  <= bus.req_wdata[int'(win_idx)*DW +: DW];
              bus.PWRITE  <= bus.req_write[win_idx];
              bus.PENABLE <= 1'b0;
              bus.gnt     <= N_REQ'(1) << win_idx;
              cur         <= win_idx;
              state       <= ST_SETUP;
            end else begin
              bus.PSEL    <= 1'b0;
              bus.PENABLE <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: begin
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: single transfers, wait states, async reset mid-transfer,
// round-robin ordering with wrap, and slave error reporting.
module tb_apb_rr_master;
  localparam int N_REQ = 4;
  localparam int AW    = 12;
  localparam int DW    = 32;

  logic       PCLK;
  logic       PRESETn;
  logic [1:0] dbg_state;
  logic [1:0] dbg_ptr;

  int n_cmp = 0;
  int n_err = 0;

  logic [N_REQ-1:0] exp_q[$];
  logic [N_REQ-1:0] exp_d[$];

  apb_rr_master_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  apb_rr_master #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .bus       (bus.master),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // One isolated transfer from requester idx with 'waits' PREADY-low ACCESS cycles.
  task automatic xfer(input int idx, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int waits,
                      input logic [DW-1:0] rdata, input logic err);
    logic [N_REQ-1:0] oh;
    oh = N_REQ'(1) << idx;
    bus.req_write[idx]         = wr;
    bus.req_addr[idx*AW +: AW] = addr;
    bus.req_wdata[idx*DW +: DW] = wdata;
    bus.req[idx]               = 1'b1;
    tick();
    check("setup_gnt", bus.gnt, oh);
    check("setup_psel", bus.PSEL, 1'b1);
    check("setup_penable", bus.PENABLE, 1'b0);
    check("setup_paddr", bus.PADDR, addr);
    check("setup_pwrite", bus.PWRITE, wr);
    if (wr) check("setup_pwdata", bus.PWDATA, wdata);
    bus.req[idx] = 1'b0;
    bus.PREADY   = 1'b0;
    bus.PRDATA   = rdata;
    bus.PSLVERR  = err;
    tick();
    for (int k = 0; k <= waits; k++) begin
      check("access_psel", bus.PSEL, 1'b1);
      check("access_penable", bus.PENABLE, 1'b1);
      check("access_paddr", bus.PADDR, addr);
      check("access_pwrite", bus.PWRITE, wr);
      if (wr) check("access_pwdata", bus.PWDATA, wdata);
      check("access_no_done", bus.done, '0);
      check("access_no_gnt", bus.gnt, '0);
      if (k == waits) bus.PREADY = 1'b1;
      tick();
    end
    check("done_pulse", bus.done, oh);
    check("done_rdata", bus.rsp_rdata, rdata);
    check("done_err", bus.rsp_err, err);
    check("done_psel_low", bus.PSEL, 1'b0);
    check("done_penable_low", bus.PENABLE, 1'b0);
    bus.PREADY  = 1'b0;
    bus.PRDATA  = ~rdata;
    bus.PSLVERR = ~err;
    tick();
    check("after_done_clear", bus.done, '0);
    check("rdata_held", bus.rsp_rdata, rdata);
    check("err_held", bus.rsp_err, err);
    check("idle_state", dbg_state, 2'd0);
    check("paddr_kept", bus.PADDR, addr);
  endtask

  // Raise all requests in r at once; exp_q/exp_d hold the expected gnt/done order.
  task automatic run_seq(input logic [N_REQ-1:0] r);
    logic started;
    started = 1'b0;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.req     = r;
    for (int cyc = 0; cyc < 40 && exp_d.size() > 0; cyc++) begin
      tick();
      if (bus.gnt != '0) begin
        if (exp_q.size() > 0) check("rr_gnt", bus.gnt, exp_q.pop_front());
        else check("rr_gnt_extra", bus.gnt, '0);
        bus.req = bus.req & ~bus.gnt;
        started = 1'b1;
      end
      if (bus.done != '0) begin
        if (exp_d.size() > 0) check("rr_done", bus.done, exp_d.pop_front());
        else check("rr_done_extra", bus.done, '0);
      end
      if (started && exp_d.size() > 0) check("rr_psel_held", bus.PSEL, 1'b1);
    end
    check("rr_all_done", exp_d.size(), 0);
    check("rr_all_gnt", exp_q.size(), 0);
    exp_d.delete();
    exp_q.delete();
    bus.req    = '0;
    bus.PREADY = 1'b0;
    tick();
    check("rr_idle_psel", bus.PSEL, 1'b0);
  endtask

  initial begin
    PRESETn       = 1'b0;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    tick();
    check("rst_psel", bus.PSEL, 1'b0);
    check("rst_gnt", bus.gnt, '0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_ptr", dbg_ptr, 2'd0);
    PRESETn = 1'b1;
    tick();

    // Single read, zero wait states.
    xfer(1, 1'b0, 12'h010, 32'h0, 0, 32'hCAFE0001, 1'b0);
    check("ptr_after_1", dbg_ptr, 2'd2);

    // Write with three wait states.
    xfer(2, 1'b1, 12'h0A5, 32'hDEADBEEF, 3, 32'h12345678, 1'b0);
    check("ptr_after_2", dbg_ptr, 2'd3);

    // Async reset during ACCESS.
    bus.req_write[3]      = 1'b1;
    bus.req_addr[3*AW +: AW] = 12'h3C3;
    bus.req[3]            = 1'b1;
    tick();
    check("rsti_gnt", bus.gnt, 4'b1000);
    bus.req[3] = 1'b0;
    bus.PREADY = 1'b0;
    tick();
    check("rsti_penable", bus.PENABLE, 1'b1);
    #1 PRESETn = 1'b0;
    #1;
    check("rsta_psel", bus.PSEL, 1'b0);
    check("rsta_penable", bus.PENABLE, 1'b0);
    check("rsta_gnt", bus.gnt, '0);
    check("rsta_done", bus.done, '0);
    check("rsta_paddr", bus.PADDR, '0);
    bus.PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    check("rsta_ptr", dbg_ptr, 2'd0);
    tick();
    check("rsta_no_done", bus.done, '0);
    check("rsta_idle", dbg_state, 2'd0);
    bus.PREADY = 1'b0;

    // All four pending: 0,1,2,3 back-to-back.
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    run_seq(4'b1111);
    check("ptr_after_rr", dbg_ptr, 2'd0);

    // Wrap: after requester 2 the pointer sits at 3, so 3 beats 0.
    exp_q = '{4'b0100};
    exp_d = '{4'b0100};
    run_seq(4'b0100);
    check("ptr_wrap_setup", dbg_ptr, 2'd3);
    exp_q = '{4'b1000, 4'b0001};
    exp_d = '{4'b1000, 4'b0001};
    run_seq(4'b1001);
    check("ptr_after_wrap", dbg_ptr, 2'd1);

    // Slave error then a clean transfer.
    xfer(0, 1'b0, 12'h7F0, 32'h0, 1, 32'h0BADF00D, 1'b1);
    xfer(1, 1'b1, 12'h004, 32'h55AA55AA, 0, 32'h00000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
